pipeline_muldiv_unit: RTL and testbench

- Iterative RV64M multiply/divide unit in the EXA stage, feeding the EXC pipeline register.
- When m_sel_EXA is high, it latches the operands and holds the front of the pipeline via mdu_stall.
- It returns the result on mdu_result with mdu_valid, which the EXA/EXC mux selects instead of the plain ALU result.
- Multiplies take a fixed 2 cycles. Divides and remainders take 1 + 64 cycles (1 + 32 for W forms), with single-cycle short-circuits for the special cases.

---
 rtl/pipeline_muldiv_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_pipeline_muldiv_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the EXA stage.
// Holds the front of the pipeline while busy and presents a registered result with a valid flag.
module pipeline_muldiv_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m_sel_EXA,
  input  logic [3:0]      alu_ctrl_EXA,
  input  logic [XLEN-1:0] reg_data1_EXA,
  input  logic [XLEN-1:0] reg_data2_EXA,
  input  logic            hold,
  input  logic            flush,
  output logic            mdu_stall,
  output logic            mdu_valid,
  output logic [XLEN-1:0] mdu_result
);

  localparam int unsigned HW = XLEN / 2;
  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned CW = 7;

  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU  = 4'd3;
  localparam logic [3:0] OP_DIV    = 4'd4;
  localparam logic [3:0] OP_DIVU   = 4'd5;
  localparam logic [3:0] OP_REM    = 4'd6;
  localparam logic [3:0] OP_REMU   = 4'd7;
  localparam logic [3:0] OP_MULW   = 4'd8;
  localparam logic [3:0] OP_DIVW   = 4'd9;
  localparam logic [3:0] OP_DIVUW  = 4'd10;
  localparam logic [3:0] OP_REMW   = 4'd11;
  localparam logic [3:0] OP_REMUW  = 4'd12;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [HW-1:0]   MIN_NEGW = {1'b1, {(HW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d;
  logic [CW-1:0]   count_q, count_d;
  logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic            valid_d;
  logic [XLEN-1:0] result_d;

  // Accept-cycle decode and operand preparation
  logic            in_is_div, in_signed, in_is_w, in_is_rem;
  logic [XLEN-1:0] a_ext, b_ext, a_ws, a_mag, b_mag, spec_res;
  logic            div_zero, div_ovf;

  always_comb begin
    in_is_div = alu_ctrl_EXA inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                                     OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    in_signed = alu_ctrl_EXA inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    in_is_w   = alu_ctrl_EXA inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    in_is_rem = alu_ctrl_EXA inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};

    a_ws = in_is_w ? {{HW{reg_data1_EXA[HW-1]}}, reg_data1_EXA[HW-1:0]} : reg_data1_EXA;
    if (in_is_w && !in_signed) begin
      a_ext = {{HW{1'b0}}, reg_data1_EXA[HW-1:0]};
      b_ext = {{HW{1'b0}}, reg_data2_EXA[HW-1:0]};
    end else if (in_is_w) begin
      a_ext = a_ws;
      b_ext = {{HW{reg_data2_EXA[HW-1]}}, reg_data2_EXA[HW-1:0]};
    end else begin
      a_ext = reg_data1_EXA;
      b_ext = reg_data2_EXA;
    end

    a_mag = (in_signed && a_ext[XLEN-1]) ? -a_ext : a_ext;
    b_mag = (in_signed && b_ext[XLEN-1]) ? -b_ext : b_ext;

    div_zero = (b_ext == '0);
    if (in_is_w)
      div_ovf = in_signed && (a_ext[HW-1:0] == MIN_NEGW) && (&b_ext[HW-1:0]);
    else
      div_ovf = in_signed && (a_ext == MIN_NEG) && (&b_ext);

    if (in_is_rem) spec_res = div_zero ? a_ws : '0;
    else           spec_res = div_zero ? '1 : a_ws;
  end

  // Multiply datapath on latched operands
  logic            mul_sa, mul_sb;
  logic [PW-1:0]   mul_a, mul_b, product;
  logic [XLEN-1:0] mul_res;

  always_comb begin
    mul_sa  = op_q inside {OP_MULH, OP_MULHSU};
    mul_sb  = (op_q == OP_MULH);
    mul_a   = {{XLEN{mul_sa & a_q[XLEN-1]}}, a_q};
    mul_b   = {{XLEN{mul_sb & b_q[XLEN-1]}}, b_q};
    product = mul_a * mul_b;
    case (op_q)
      OP_MUL:                       mul_res = product[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: mul_res = product[PW-1:XLEN];
      OP_MULW:                      mul_res = {{HW{product[HW-1]}}, product[HW-1:0]};
      default:                      mul_res = '0;
    endcase
  end

  // Restoring divide step and final sign fixup
  logic            q_is_w, q_is_rem, div_ge;
  logic [XLEN:0]   div_shift, div_trial;
  logic [XLEN-1:0] quo_nx, rem_nx, quo_fix, rem_fix, div_raw, div_res;

  always_comb begin
    q_is_w    = op_q inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    q_is_rem  = op_q inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    div_shift = {rem_q, quo_q[XLEN-1]};
    div_trial = div_shift - {1'b0, b_q};
    div_ge    = ~div_trial[XLEN];
    rem_nx    = div_ge ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
    quo_nx    = {quo_q[XLEN-2:0], div_ge};
    quo_fix   = neg_quo_q ? -quo_nx : quo_nx;
    rem_fix   = neg_rem_q ? -rem_nx : rem_nx;
    div_raw   = q_is_rem ? rem_fix : quo_fix;
    div_res   = q_is_w ? {{HW{div_raw[HW-1]}}, div_raw[HW-1:0]} : div_raw;
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    mdu_stall = 1'b0;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    count_d   = count_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = mdu_result;

    case (state_q)
      S_IDLE: begin
        if (m_sel_EXA && !flush) begin
          mdu_stall = 1'b1;
          op_d      = alu_ctrl_EXA;
          a_d       = a_ext;
          b_d       = b_ext;
          neg_quo_d = in_signed & (a_ext[XLEN-1] ^ b_ext[XLEN-1]);
          neg_rem_d = in_signed & a_ext[XLEN-1];
          if (!in_is_div) begin
            state_d = S_MUL;
          end else if (div_zero || div_ovf) begin
            state_d  = S_DONE;
            result_d = spec_res;
          end else begin
            state_d = S_DIV;
            b_d     = b_mag;
            rem_d   = '0;
            quo_d   = in_is_w ? {a_mag[HW-1:0], {HW{1'b0}}} : a_mag;
            count_d = in_is_w ? CW'(HW) : CW'(XLEN);
          end
        end
      end
      S_MUL: begin
        mdu_stall = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = mul_res;
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        mdu_stall = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          quo_d   = quo_nx;
          rem_d   = rem_nx;
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            result_d = div_res;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (flush || !hold) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      mdu_valid  <= 1'b0;
      mdu_result <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      mdu_valid  <= valid_d;
      mdu_result <= result_d;
    end
  end

endmodule

// File: tb/tb_pipeline_muldiv_unit.sv
// Directed scoreboard bench for pipeline_muldiv_unit: results, latencies, hold, flush and reset.
module tb_pipeline_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_sel_EXA;
  logic [3:0]  alu_ctrl_EXA;
  logic [63:0] reg_data1_EXA;
  logic [63:0] reg_data2_EXA;
  logic        hold;
  logic        flush;
  logic        mdu_stall;
  logic        mdu_valid;
  logic [63:0] mdu_result;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   fail_cnt  = 0;

  always #5 clk = ~clk;

  pipeline_muldiv_unit #(.XLEN(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .m_sel_EXA    (m_sel_EXA),
    .alu_ctrl_EXA (alu_ctrl_EXA),
    .reg_data1_EXA(reg_data1_EXA),
    .reg_data2_EXA(reg_data2_EXA),
    .hold         (hold),
    .flush        (flush),
    .mdu_stall    (mdu_stall),
    .mdu_valid    (mdu_valid),
    .mdu_result   (mdu_result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Drive an op during one cycle; returns just after the accept edge.
  task automatic start_op(input string tag, input logic [3:0] op,
                          input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    m_sel_EXA     = 1'b1;
    alu_ctrl_EXA  = op;
    reg_data1_EXA = a;
    reg_data2_EXA = b;
    #1 check({tag, "_stall_accept"}, 64'(mdu_stall), 64'd1);
    @(posedge clk);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int lat, input int hold_n);
    exp_t e;
    int   cyc;
    bit   stall_ok;
    hold = (hold_n > 0);
    sb_q.push_back('{res: exp_res, lat: lat});
    start_op(tag, op, a, b);
    cyc      = 0;
    stall_ok = 1'b1;
    do begin
      @(negedge clk);
      m_sel_EXA = 1'b0;
      cyc++;
      if (!mdu_valid && mdu_stall !== 1'b1) stall_ok = 1'b0;
    end while (!mdu_valid && cyc < 200);
    if (lat > 1) check({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
    check({tag, "_valid"}, 64'(mdu_valid), 64'd1);
    e = sb_q.pop_front();
    check({tag, "_result"}, mdu_result, e.res);
    check({tag, "_latency"}, 64'(cyc), 64'(e.lat));
    check({tag, "_stall_done"}, 64'(mdu_stall), 64'd0);
    for (int i = 0; i < hold_n; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(mdu_valid), 64'd1);
      check({tag, "_hold_result"}, mdu_result, e.res);
      check({tag, "_hold_stall"}, 64'(mdu_stall), 64'd0);
      if (i == hold_n - 1) hold = 1'b0;
    end
    @(negedge clk);
    check({tag, "_valid_clear"}, 64'(mdu_valid), 64'd0);
  endtask

  task automatic watch_idle(input string tag, input int n);
    bit stale = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mdu_valid !== 1'b0 || mdu_stall !== 1'b0) stale = 1'b1;
    end
    check(tag, 64'(stale), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; m_sel_EXA = 1'b0; alu_ctrl_EXA = 4'd0;
    reg_data1_EXA = '0; reg_data2_EXA = '0; hold = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_stall", 64'(mdu_stall), 64'd0);
    check("reset_valid", 64'(mdu_valid), 64'd0);
    check("reset_result", mdu_result, 64'd0);
    reset = 1'b1;

    // Multiplies
    run_op("mul",    4'd0, 64'd7, -64'd3, 64'hFFFF_FFFF_FFFF_FFEB, 2, 0);
    run_op("mulhu",  4'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 2, 0);
    run_op("mulhsu", 4'd2, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
    run_op("mulw",   4'd8, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2, 0);
    run_op("resv13", 4'd13, 64'd5, 64'd9, 64'd0, 2, 0);

    // 64-bit divides
    run_op("div",     4'd4, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    run_op("rem",     4'd6, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("divu",    4'd5, '1, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("div_min", 4'd4, 64'h8000_0000_0000_0000, 64'd2, 64'hC000_0000_0000_0000, 65, 0);

    // Special cases
    run_op("divu_z",   4'd5, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("remu_z",   4'd7, 64'd5, 64'd0, 64'd5, 1, 0);
    run_op("div_ovf",  4'd4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
    run_op("rem_ovf",  4'd6, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
    run_op("divw_ovf", 4'd9, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("divuw_z",  4'd10, 64'd77, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("remw_z",   4'd11, 64'h8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1, 0);

    // W divides
    run_op("remuw", 4'd12, 64'h1_0000_0007, 64'd2, 64'd1, 33, 0);
    run_op("divw",  4'd9, -64'd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 33, 0);
    run_op("remw",  4'd11, -64'd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);

    // Hold in DONE
    run_op("mulh_hold", 4'd1, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 2, 3);

    // Flush mid-divide
    start_op("div_flush", 4'd4, 64'd100, 64'd7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      m_sel_EXA = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_valid", 64'(mdu_valid), 64'd0);
    check("flush_stall", 64'(mdu_stall), 64'd0);
    watch_idle("flush_no_stale", 80);
    run_op("divu_after_flush", 4'd5, 64'd100, 64'd7, 64'd14, 65, 0);

    // Reset pulse mid-divide
    start_op("div_reset", 4'd4, -64'd100, 64'd7);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      m_sel_EXA = 1'b0;
    end
    reset = 1'b0;
    #1;
    check("rst_mid_stall", 64'(mdu_stall), 64'd0);
    check("rst_mid_valid", 64'(mdu_valid), 64'd0);
    check("rst_mid_result", mdu_result, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    watch_idle("reset_no_stale", 80);
    run_op("rem_after_reset", 4'd6, 64'd7, -64'd2, 64'd1, 65, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
